// File: rtl/systolic_skew_feeder.sv
// ---------------------------------------------------------------------------
// systolic_skew_feeder
//
// Operand feeder for the edge of a systolic MAC array. A whole operand block
// (LANES lanes of DEPTH elements) is accepted in one load handshake, then
// streamed one element per lane per enabled step, element 0 first. Lane i is
// delayed by i steps so that operands reach successive PE rows/columns
// aligned. Outside a lane's window the lane outputs zero with valid low.
//
// Handshake: a load transfers on every rising edge where load_valid and
// load_ready are both 1. load_ready depends on state only; load_valid may be
// asserted at any time and is simply ignored while load_ready is 0. A start
// that coincides with load_valid in LOADED wins and that load is discarded.
//
// Ports
//   clk        clock, all state on rising edge
//   reset      asynchronous, active-high
//   load_valid load_data is valid
//   load_ready feeder can accept a block (IDLE or LOADED)
//   load_data  LANES*DEPTH*DATA_W; lane i at [(i+1)*DEPTH*DATA_W-1 -: ...],
//              element 0 in the top DATA_W bits of its lane field
//   start      begin streaming the held block (LOADED only)
//   enable     advance one step while streaming; 0 stalls
//   data_out   LANES*DATA_W; lane i at [(i+1)*DATA_W-1 -: DATA_W]
//   out_valid  per-lane element-valid flag
//   busy       streaming in progress
//   done       one-cycle pulse, coincident with return to IDLE
//   state_dbg  current FSM state (0 IDLE, 1 LOADED, 2 RUN)
// ---------------------------------------------------------------------------
module systolic_skew_feeder #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 7,
  parameter int LANES  = 4
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            load_valid,
  output logic                            load_ready,
  input  logic [LANES*DEPTH*DATA_W-1:0]   load_data,
  input  logic                            start,
  input  logic                            enable,
  output logic [LANES*DATA_W-1:0]         data_out,
  output logic [LANES-1:0]                out_valid,
  output logic                            busy,
  output logic                            done,
  output logic [1:0]                      state_dbg
);

  localparam int BLK_W  = LANES * DEPTH * DATA_W;
  localparam int LANE_W = DEPTH * DATA_W;
  localparam int LAST   = DEPTH + LANES - 2;
  // Wide enough to hold DEPTH+LANES-1, the largest window bound compared.
  localparam int T_W    = $clog2(DEPTH + LANES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOADED = 2'd1,
    RUN    = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [T_W-1:0]     t_q, t_d;
  logic [BLK_W-1:0]   blk_q, blk_d;
  logic               done_q, done_d;

  // -------------------------------------------------------------------------
  // State register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      t_q     <= '0;
      blk_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      t_q     <= t_d;
      blk_q   <= blk_d;
      done_q  <= done_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic and state-derived handshake outputs
  // -------------------------------------------------------------------------
  always_comb begin
    state_d    = state_q;
    t_d        = t_q;
    blk_d      = blk_q;
    done_d     = 1'b0;
    load_ready = (state_q != RUN);
    busy       = (state_q == RUN);

    case (state_q)
      IDLE: begin
        if (load_valid) begin
          blk_d   = load_data;
          t_d     = '0;
          state_d = LOADED;
        end
      end
      LOADED: begin
        if (start) begin
          t_d     = '0;
          state_d = RUN;
        end else if (load_valid) begin
          blk_d = load_data;
        end
      end
      RUN: begin
        if (enable) begin
          if (t_q == T_W'(LAST)) begin
            t_d     = '0;
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            t_d = t_q + T_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        t_d     = '0;
      end
    endcase
  end

  assign done      = done_q;
  assign state_dbg = state_q;

  // -------------------------------------------------------------------------
  // Per-lane output mux, indexed by the step counter. Storage stays put
  // during RUN; lane i shows element k = t - i inside its window.
  // -------------------------------------------------------------------------
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [LANE_W-1:0] lane_field;
    logic [T_W-1:0]    k;
    logic              in_win;
    logic [DATA_W-1:0] sel;

    assign lane_field = blk_q[i*LANE_W +: LANE_W];
    // When t < i the subtraction wraps to at least 2^T_W-(LANES-1), which
    // always exceeds DEPTH, so one unsigned compare covers both bounds.
    assign k      = t_q - T_W'(i);
    assign in_win = (state_q == RUN) && (k < T_W'(DEPTH));

    always_comb begin
      sel = '0;
      for (int j = 0; j < DEPTH; j++) begin
        if (k == T_W'(j)) begin
          sel = lane_field[(DEPTH-1-j)*DATA_W +: DATA_W];
        end
      end
    end

    assign data_out[i*DATA_W +: DATA_W] = in_win ? sel : '0;
    assign out_valid[i]                 = in_win;
  end

endmodule
